// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and framing constants for the UART ALU responder.
// ALU_MUL_EN selects whether the MUL opcode is recognised.
package alu_pkg;

  localparam logic [7:0] OP_ECHO_C = 8'hEC;
  localparam logic [7:0] OP_ADD_C  = 8'hA8;
  localparam logic [7:0] OP_MUL_C  = 8'h88;

  localparam int HDR_BYTES_C     = 4;
  localparam int ACC_WIDTH_C     = 32;
  localparam int OPERAND_BYTES_C = ACC_WIDTH_C / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ECHO,
    ST_LOAD,
    ST_DROP,
    ST_SEND
  } state_e;

endpackage

// File: rtl/uart_alu_responder_if.sv
// Byte-stream bus: a byte moves on a clock edge where tvalid and tready are both high,
// and the master holds tdata/tvalid stable while tvalid=1 and tready=0.
interface uart_alu_responder_if #(
  parameter int DATA_WIDTH_P = 8
);
  logic [DATA_WIDTH_P-1:0] tdata;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_out_reg.sv
// Single-entry output register feeding the transmit stream; a load wins over a
// handshake, so back-to-back bytes stream without a bubble.
module axis_out_reg #(
  parameter int DATA_WIDTH_P = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [DATA_WIDTH_P-1:0] load_data,
  uart_alu_responder_if.master    tx
);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx.tvalid <= 1'b0;
      tx.tdata  <= '0;
    end else if (load) begin
      tx.tvalid <= 1'b1;
      tx.tdata  <= load_data;
    end else if (tx.tvalid && tx.tready) begin
      tx.tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_alu_responder.sv
// Packet responder: ECHO payload, ADD/MUL accumulate operands, DROP malformed packets.
// Define ALU_MUL_EN to compile in the MUL opcode and multiplier.
module uart_alu_responder
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH_P = 8,
  parameter int ACC_WIDTH_P  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH_P-1:0] rx_tdata_i,
  input  logic                    rx_tvalid_i,
  output logic                    rx_tready_o,
  output logic [DATA_WIDTH_P-1:0] tx_tdata_o,
  output logic                    tx_tvalid_o,
  input  logic                    tx_tready_i,
  output logic                    err_o,
  output logic                    busy_o
);

  localparam int OPB = ACC_WIDTH_P / 8;
  localparam int BW  = (OPB > 1) ? $clog2(OPB) : 1;
  localparam logic [BW-1:0] BIDX_LAST = BW'(OPB - 1);

  state_e                   state_q, state_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [7:0]               op_q, op_d;
  logic [7:0]               len_lo_q, len_lo_d;
  logic [ACC_WIDTH_P-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH_P-1:0]   opnd_q, opnd_d;
  logic [BW-1:0]            bidx_q, bidx_d;
  logic                     first_q, first_d;
  logic                     err_q, err_d;

  logic                     rx_ready, rx_fire, tx_free;
  logic                     out_load, is_alu_op, len_ok;
  logic [DATA_WIDTH_P-1:0]  out_data;
  logic [15:0]              len_full;
  logic [ACC_WIDTH_P-1:0]   opnd_next, alu_res, acc_shift;

  uart_alu_responder_if #(.DATA_WIDTH_P(DATA_WIDTH_P)) tx_if ();

  axis_out_reg #(.DATA_WIDTH_P(DATA_WIDTH_P)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (out_load),
    .load_data (out_data),
    .tx        (tx_if.master)
  );

  assign tx_if.tready = tx_tready_i;
  assign tx_tdata_o   = tx_if.tdata;
  assign tx_tvalid_o  = tx_if.tvalid;
  assign rx_tready_o  = rx_ready && !rst;
  assign err_o        = err_q;
  assign busy_o       = (state_q != ST_IDLE);

  assign rx_fire   = rx_tvalid_i && rx_ready;
  assign tx_free   = !tx_if.tvalid || tx_tready_i;
  assign len_full  = {rx_tdata_i, len_lo_q};
  // Operands arrive LSB first, so each new byte enters at the top and shifts down.
  assign opnd_next = (opnd_q >> 8) | (ACC_WIDTH_P'(rx_tdata_i) << (ACC_WIDTH_P - 8));
  assign acc_shift = acc_q >> {cnt_q, 3'b000};
  assign len_ok    = (len_full >= 16'(HDR_BYTES_C + OPB)) &&
                     (((len_full - 16'(HDR_BYTES_C)) % 16'(OPB)) == 16'd0);

  always_comb begin
    is_alu_op = (op_q == OP_ADD_C);
    alu_res   = acc_q + opnd_next;
`ifdef ALU_MUL_EN
    if (op_q == OP_MUL_C) begin
      is_alu_op = 1'b1;
      alu_res   = acc_q * opnd_next;
    end
`endif
    if (first_q) alu_res = opnd_next;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    len_lo_d = len_lo_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    bidx_d   = bidx_q;
    first_d  = first_q;
    err_d    = 1'b0;
    rx_ready = 1'b0;
    out_load = 1'b0;
    out_data = '0;
    case (state_q)
      ST_IDLE: begin
        rx_ready = 1'b1;
        if (rx_fire) begin
          op_d    = rx_tdata_i;
          cnt_d   = 16'd1;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        rx_ready = 1'b1;
        if (rx_fire) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == 16'd2) len_lo_d = rx_tdata_i;
          if (cnt_q == 16'(HDR_BYTES_C - 1)) begin
            // Remaining payload count; LEN <= 4 never enters a counting state.
            cnt_d = len_full - 16'(HDR_BYTES_C);
            if (op_q == OP_ECHO_C) begin
              state_d = (len_full > 16'(HDR_BYTES_C)) ? ST_ECHO : ST_IDLE;
            end else if (is_alu_op && len_ok) begin
              state_d = ST_LOAD;
              bidx_d  = '0;
              first_d = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = (len_full > 16'(HDR_BYTES_C)) ? ST_DROP : ST_IDLE;
            end
          end
        end
      end
      ST_ECHO: begin
        rx_ready = tx_free;
        if (rx_fire) begin
          out_load = 1'b1;
          out_data = rx_tdata_i;
          cnt_d    = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        rx_ready = 1'b1;
        if (rx_fire) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Gated on a free output slot so the first result byte can load on the last operand byte.
        rx_ready = tx_free;
        if (rx_fire) begin
          opnd_d = opnd_next;
          cnt_d  = cnt_q - 16'd1;
          if (bidx_q == BIDX_LAST) begin
            acc_d   = alu_res;
            first_d = 1'b0;
            bidx_d  = '0;
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
          if (cnt_q == 16'd1) begin
            state_d  = ST_SEND;
            out_load = 1'b1;
            out_data = alu_res[DATA_WIDTH_P-1:0];
            cnt_d    = 16'd1;
          end
        end
      end
      ST_SEND: begin
        // cnt_q counts result bytes already loaded into the output register.
        if (tx_if.tvalid && tx_tready_i) begin
          if (cnt_q == 16'(OPB)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            out_load = 1'b1;
            out_data = acc_shift[DATA_WIDTH_P-1:0];
            cnt_d    = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      len_lo_q <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      bidx_q   <= '0;
      first_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      len_lo_q <= len_lo_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      bidx_q   <= bidx_d;
      first_q  <= first_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_alu_responder.sv
// Directed bench for uart_alu_responder: packet-level reference model, per-cycle tx monitor
// and literal expectations for the canonical packets.
module tb_uart_alu_responder;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err, busy;

  uart_alu_responder_if #(.DATA_WIDTH_P(8)) rx_bus ();
  uart_alu_responder_if #(.DATA_WIDTH_P(8)) tx_bus ();

  uart_alu_responder #(.DATA_WIDTH_P(8), .ACC_WIDTH_P(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_tdata_i  (rx_bus.tdata),
    .rx_tvalid_i (rx_bus.tvalid),
    .rx_tready_o (rx_bus.tready),
    .tx_tdata_o  (tx_bus.tdata),
    .tx_tvalid_o (tx_bus.tvalid),
    .tx_tready_i (tx_bus.tready),
    .err_o       (err),
    .busy_o      (busy)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: whole packet in, expected response bytes pushed to exp_q, returns err.
  function automatic bit model_packet(input bq_t pkt);
    int len;
    logic [31:0] acc, opnd;
    bit is_alu;
    len    = int'({pkt[3], pkt[2]});
    is_alu = (pkt[0] == 8'hA8);
`ifdef ALU_MUL_EN
    if (pkt[0] == 8'h88) is_alu = 1'b1;
`endif
    if (pkt[0] == 8'hEC) begin
      for (int i = 4; i < len; i++) exp_q.push_back(pkt[i]);
      return 1'b0;
    end
    if (is_alu && len >= 8 && ((len - 4) % 4) == 0) begin
      acc = 32'd0;
      for (int k = 0; k < (len - 4) / 4; k++) begin
        opnd = {pkt[4*k+7], pkt[4*k+6], pkt[4*k+5], pkt[4*k+4]};
        if (k == 0) acc = opnd;
        else if (pkt[0] == 8'hA8) acc = acc + opnd;
        else acc = acc * opnd;
      end
      for (int i = 0; i < 4; i++) exp_q.push_back(acc[8*i +: 8]);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  // ---------------- tx monitor: every cycle, sampled at negedge+2 ----------------
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("tx hold valid", tx_bus.tvalid, 1'b1);
          check("tx hold data", tx_bus.tdata, prev_data);
        end
        if (tx_bus.tvalid && tx_bus.tready) begin
          if (exp_q.size() == 0) begin
            check("tx unexpected byte", 32'd1, 32'd0);
          end else begin
            check("tx byte", tx_bus.tdata, exp_q.pop_front());
          end
          got_q.push_back(tx_bus.tdata);
        end
        prev_stall = tx_bus.tvalid && !tx_bus.tready;
        prev_data  = tx_bus.tdata;
        if (err) err_seen++;
      end
    end
  end

  // ---------------- driver tasks (called and return at a negedge) ----------------
  task automatic send_byte(input logic [7:0] b);
    int   guard;
    logic seen;
    guard = 0;
    rx_bus.tdata  = b;
    rx_bus.tvalid = 1'b1;
    forever begin
      #1 seen = rx_bus.tready;
      @(negedge clk);
      if (seen) break;
      guard++;
      if (guard > 500) begin
        check("rx accept timeout", 32'd1, 32'd0);
        break;
      end
    end
    rx_bus.tvalid = 1'b0;
  endtask

  task automatic send_all(input bq_t pkt);
    foreach (pkt[i]) send_byte(pkt[i]);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check({name, " drain"}, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_packet(input string name, input bq_t pkt, input bit use_lit,
                            input bq_t lit, input bit lit_err, input bit toggle);
    bq_t model_bytes;
    bit  exp_err;
    got_q.delete();
    err_seen = 0;
    exp_err = model_packet(pkt);
    model_bytes = exp_q;
    if (use_lit) begin
      check({name, " model err"}, exp_err, lit_err);
      check({name, " model count"}, model_bytes.size(), lit.size());
      for (int i = 0; i < lit.size() && i < model_bytes.size(); i++)
        check({name, " model byte"}, model_bytes[i], lit[i]);
    end
    if (toggle) begin
      fork
        send_all(pkt);
        begin
          for (int i = 0; i < 400; i++) begin
            tx_bus.tready = 1'($urandom_range(0, 1));
            @(negedge clk);
          end
          tx_bus.tready = 1'b1;
        end
      join
    end else begin
      send_all(pkt);
    end
    drain(name);
    check({name, " byte count"}, got_q.size(), model_bytes.size());
    check({name, " err pulses"}, err_seen, exp_err ? 1 : 0);
    check({name, " busy after"}, busy, 1'b0);
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    @(negedge clk);
    #3;
    check({name, " rx_tready"}, rx_bus.tready, 1'b0);
    check({name, " tx_tvalid"}, tx_bus.tvalid, 1'b0);
    check({name, " tx_tdata"}, tx_bus.tdata, 8'h00);
    check({name, " err"}, err, 1'b0);
    check({name, " busy"}, busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    #3;
    check({name, " rx_tready after"}, rx_bus.tready, 1'b1);
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bq_t pkt, lit, none;
    none.delete();
    rx_bus.tdata  = 8'h00;
    rx_bus.tvalid = 1'b0;
    tx_bus.tready = 1'b1;
    @(negedge clk);
    do_reset("reset");

    pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
    lit = '{8'h41, 8'h42, 8'h43};
    run_packet("echo", pkt, 1'b1, lit, 1'b0, 1'b0);
    check("echo first byte", got_q.size() > 0 ? got_q[0] : 8'hXX, 8'h41);

    pkt = '{8'hA8, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    lit = '{8'h01, 8'h00, 8'h00, 8'h00};
    run_packet("add wrap", pkt, 1'b1, lit, 1'b0, 1'b0);

    pkt = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
`ifdef ALU_MUL_EN
    lit = '{8'h0F, 8'h00, 8'h00, 8'h00};
    run_packet("mul", pkt, 1'b1, lit, 1'b0, 1'b0);
`else
    run_packet("mul disabled", pkt, 1'b1, none, 1'b1, 1'b0);
`endif
    pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h5A, 8'hA5};
    lit = '{8'h5A, 8'hA5};
    run_packet("echo after mul", pkt, 1'b1, lit, 1'b0, 1'b0);

    pkt = '{8'hA8, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
    run_packet("bad len", pkt, 1'b1, none, 1'b1, 1'b0);

    pkt = '{8'hA8, 8'h00, 8'h09, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_packet("bad len mod", pkt, 1'b1, none, 1'b1, 1'b0);

    pkt = '{8'hEC, 8'h00, 8'h04, 8'h00};
    run_packet("echo len4", pkt, 1'b1, none, 1'b0, 1'b0);

    pkt = '{8'h55, 8'h00, 8'h04, 8'h00};
    run_packet("unknown len4", pkt, 1'b1, none, 1'b1, 1'b0);

    pkt = '{8'hA8, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
            8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    lit = '{8'h06, 8'h00, 8'h00, 8'h00};
    run_packet("add three", pkt, 1'b1, lit, 1'b0, 1'b0);

    // Backpressure on the ADD result.
    tx_bus.tready = 1'b0;
    pkt = '{8'hA8, 8'h00, 8'h0C, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h01, 8'h02, 8'h03, 8'h04};
    lit = '{8'h11, 8'h22, 8'h33, 8'h44};
    got_q.delete();
    err_seen = 0;
    void'(model_packet(pkt));
    check("bp model count", exp_q.size(), 4);
    send_all(pkt);
    for (int i = 0; i < 10; i++) begin
      #3;
      check("bp tx_tvalid", tx_bus.tvalid, 1'b1);
      check("bp tx_tdata", tx_bus.tdata, 8'h11);
      check("bp rx_tready", rx_bus.tready, 1'b0);
      check("bp busy", busy, 1'b1);
      @(negedge clk);
    end
    tx_bus.tready = 1'b1;
    drain("bp");
    check("bp byte count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check("bp byte", got_q[i], lit[i]);
    check("bp busy after", busy, 1'b0);

    // Reset in the middle of operand loading.
    send_byte(8'hA8); send_byte(8'h00); send_byte(8'h0C); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02);
    check("mid load busy", busy, 1'b1);
    do_reset("mid reset");
    pkt = '{8'hA8, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    lit = '{8'h0C, 8'h00, 8'h00, 8'h00};
    run_packet("add after reset", pkt, 1'b1, lit, 1'b0, 1'b0);

    // Long echo with a 16-bit length and random transmit backpressure.
    pkt = '{8'hEC, 8'h00, 8'h23, 8'h01};
    for (int i = 0; i < 16'h0123 - 4; i++) pkt.push_back(8'((i * 7 + 3) & 8'hFF));
    run_packet("long echo", pkt, 1'b0, none, 1'b0, 1'b1);

    // Long drop: unknown opcode with a 16-bit length.
    pkt = '{8'h13, 8'h00, 8'h03, 8'h01};
    for (int i = 0; i < 16'h0103 - 4; i++) pkt.push_back(8'(i & 8'hFF));
    run_packet("long drop", pkt, 1'b1, none, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_alu_responder.md
UART_ALU_RESPONDER -- requirements
Module: uart_alu_responder

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH_P, default 8, byte width of both streams; only 8 is supported.
REQ-002 The module SHALL have parameter ACC_WIDTH_P, default 32, accumulator and operand width; it must be a multiple of 8.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port rx_tdata_i, input, DATA_WIDTH_P bits: command byte from the UART receiver's m_axis.
REQ-006 The module SHALL have ports rx_tvalid_i (input, 1 bit) and rx_tready_o (output, 1 bit): the receive-stream handshake.
REQ-007 The module SHALL have port tx_tdata_o, output, DATA_WIDTH_P bits: response byte to the UART transmitter's s_axis.
REQ-008 The module SHALL have ports tx_tvalid_o (output, 1 bit) and tx_tready_i (input, 1 bit): the transmit-stream handshake.
REQ-009 The module SHALL have port err_o, output, 1 bit: one-cycle pulse when a packet is rejected.
REQ-010 The module SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 The packet format SHALL be: byte0 opcode, byte1 reserved (ignored), byte2 LEN low, byte3 LEN high; LEN is the total packet bytes including the 4-byte header; operands and results are little-endian.
REQ-012 The opcodes SHALL be ECHO=0xEC, ADD=0xA8 and MUL=0x88; any other value is unknown.
REQ-013 The states SHALL be IDLE, HDR, ECHO, LOAD, DROP and SEND.
- IDLE goes to HDR on the first accepted byte.
- After byte3, HDR goes to ECHO, LOAD, DROP or IDLE.
REQ-014 A byte SHALL transfer only on a cycle where valid and ready are both high; tx_tdata_o SHALL hold stable while tx_tvalid_o=1 and tx_tready_i=0.
REQ-015 ECHO SHALL forward LEN-4 payload bytes through a single-entry output register.
- Response latency is 1 cycle.
- rx_tready_o = !tx_tvalid_o || tx_tready_i.
- LEN=4 produces no output and returns to IDLE.
REQ-016 ADD/MUL SHALL require LEN>=8 and (LEN-4)%4==0.
- Each 4-byte operand is assembled in LOAD.
- The first operand loads the accumulator.
- Each later operand is added (ADD) or multiplied, keeping the low ACC_WIDTH_P bits (MUL).
- Overflow wraps modulo 2^ACC_WIDTH_P.
REQ-017 After the last operand byte is accepted, SEND SHALL assert tx_tvalid_o on the next cycle and emit 4 result bytes LSB first.
- rx_tready_o = 0 throughout SEND.
- The module returns to IDLE after the 4th handshake.
REQ-018 An unknown opcode, or an ADD/MUL packet with a bad LEN, SHALL:
- pulse err_o for exactly 1 cycle after byte3;
- enter DROP, accepting and discarding LEN-4 bytes with rx_tready_o = 1;
- return to IDLE when the count is exhausted, or directly after byte3 if LEN<=4.
REQ-019 The byte counter SHALL be 16 bits; LEN=0xFFFF SHALL be handled without counter wrap.
REQ-020 The module SHALL have no timeout; a stalled packet holds its state indefinitely.

Reset
REQ-021 On rst=1, at any point including mid-packet or mid-SEND, the state SHALL go to IDLE and the counter and accumulator to 0.
- Outputs: rx_tready_o=0, tx_tvalid_o=0, tx_tdata_o=0, err_o=0, busy_o=0.
- rx_tready_o goes to 1 in the first cycle after rst deasserts.

Configuration
REQ-022 The macro ALU_MUL_EN SHALL gate the multiplier.
- Defined: the MUL opcode and multiplier are compiled in.
- Undefined: 0x88 is treated as an unknown opcode (err_o pulse, DROP) and no multiplier is synthesized.

Structure
REQ-023 The package alu_pkg SHALL hold:
- the opcode constants;
- the state enum typedef;
- HDR_BYTES_C=4;
- OPERAND_BYTES_C=ACC_WIDTH_P/8, with default 4.
REQ-024 The single-entry AXI-stream output register SHALL be the sub-module axis_out_reg, shared by ECHO and SEND.

Verification
REQ-025 ECHO: send EC 00 07 00 41 42 43 -> tx emits 41 42 43; err_o stays 0.
REQ-026 ADD wrap: send A8 00 0C 00 FF FF FF FF 02 00 00 00 -> tx emits 01 00 00 00.
REQ-027 MUL: send 88 00 0C 00 03 00 00 00 05 00 00 00.
- With ALU_MUL_EN: tx emits 0F 00 00 00.
- Without it: one err_o pulse, no tx output, and a following ECHO packet is still correct.
REQ-028 Bad LEN: send A8 00 06 00 11 22 -> one err_o pulse, 2 bytes dropped, no tx output, busy_o=0 afterwards.
REQ-029 Backpressure: hold tx_tready_i=0 for 10 cycles during an ADD result -> tx_tdata_o stable, rx_tready_o=0, and all 4 bytes are delivered once ready returns.
REQ-030 Reset mid-LOAD: assert rst after 2 operand bytes -> all outputs at reset values, and the next ADD packet produces the correct sum.
